jtag_master_shifter: RTL and testbench

//  Host-side JTAG initiator: generates TCK from the system clock and shifts a TMS/TDI bit vector into
//  the target TAP. Captures TDO into a parallel response word. Drives TMS/TDI on TCK falling edges and

---
 rtl/jtag_pkg.sv | 20 ++
 rtl/tck_phase_gen.sv | 37 +++
 rtl/jtag_master_shifter.sv | 195 +++++++++++++++++++
 tb/tb_jtag_master_shifter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared types and helpers for the JTAG master shifter.
package jtag_pkg;

  // Command sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // TCK half-period in CLK cycles used when the parent does not override it.
  localparam int DEFAULT_DIV = 4;

  // Counter width able to hold 0..value-1, never narrower than one bit.
  function automatic int width_min1(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/tck_phase_gen.sv
// TCK phase timer: counts DIV CLK cycles per TCK half-period and flags the
// last cycle of the current half as a rise (TCK low) or fall (TCK high) strobe.
module tck_phase_gen
  import jtag_pkg::*;
#(
  parameter int DIV = DEFAULT_DIV
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_tck,
  output logic o_rise_stb,
  output logic o_fall_stb
);

  localparam int CNT_W = width_min1(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last     = i_en && (r_cnt == CNT_LAST);
  assign o_rise_stb = w_last && !i_tck;
  assign o_fall_stb = w_last && i_tck;

  // Half-period counter: held at zero while disabled, restarts every half-period.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (!i_en || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/jtag_master_shifter.sv
// Host-side JTAG initiator: generates TCK from CLK, shifts a TMS/TDI vector
// out LSB first (changing pins only while TCK is low) and gathers TDO, sampled
// on the last CLK cycle of each TCK-high phase, into a parallel response word.
module jtag_master_shifter
  import jtag_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DIV    = DEFAULT_DIV,
  parameter int LEN_W  = $clog2(DATA_W + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [LEN_W-1:0]  CMD_LEN,
  input  logic [DATA_W-1:0] CMD_TMS,
  input  logic [DATA_W-1:0] CMD_TDI,
  output logic              RSP_VALID,
  output logic [DATA_W-1:0] RSP_TDO,
  output logic              TCK,
  output logic              TMS,
  output logic              TDI,
  input  logic              TDO
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DATA_W);

  // Registered state
  state_t             r_state;
  logic               r_tck;
  logic               r_tms;
  logic               r_tdi;
  logic               r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_tdo;
  logic [DATA_W-1:0]  r_tms_sh;   // bits still to be driven, next one in bit 0
  logic [DATA_W-1:0]  r_tdi_sh;
  logic [DATA_W-1:0]  r_mask;     // one-hot position of the current bit in RSP_TDO
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_idx;

  // Next-state values
  state_t             w_state_nxt;
  logic               w_tck_nxt;
  logic               w_tms_nxt;
  logic               w_tdi_nxt;
  logic               w_rsp_valid_nxt;
  logic [DATA_W-1:0]  w_rsp_tdo_nxt;
  logic [DATA_W-1:0]  w_tms_sh_nxt;
  logic [DATA_W-1:0]  w_tdi_sh_nxt;
  logic [DATA_W-1:0]  w_mask_nxt;
  logic [LEN_W-1:0]   w_len_nxt;
  logic [LEN_W-1:0]   w_idx_nxt;

  logic [LEN_W-1:0]   w_len_clamp;
  logic [LEN_W-1:0]   w_idx_inc;
  logic               w_phase_en;
  logic               w_rise_stb;
  logic               w_fall_stb;

  assign w_len_clamp = (CMD_LEN > LEN_MAX) ? LEN_MAX : CMD_LEN;
  assign w_idx_inc   = r_idx + LEN_W'(1);
  assign w_phase_en  = (r_state == ST_LOW) || (r_state == ST_HIGH);

  assign CMD_READY = (r_state == ST_IDLE);
  assign RSP_VALID = r_rsp_valid;
  assign RSP_TDO   = r_rsp_tdo;
  assign TCK       = r_tck;
  assign TMS       = r_tms;
  assign TDI       = r_tdi;

  tck_phase_gen #(
    .DIV (DIV)
  ) u_phase (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_en       (w_phase_en),
    .i_tck      (r_tck),
    .o_rise_stb (w_rise_stb),
    .o_fall_stb (w_fall_stb)
  );

  // Sequencer next-state and datapath updates; everything holds unless changed.
  always_comb begin
    w_state_nxt     = r_state;
    w_tck_nxt       = r_tck;
    w_tms_nxt       = r_tms;
    w_tdi_nxt       = r_tdi;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_tdo_nxt   = r_rsp_tdo;
    w_tms_sh_nxt    = r_tms_sh;
    w_tdi_sh_nxt    = r_tdi_sh;
    w_mask_nxt      = r_mask;
    w_len_nxt       = r_len;
    w_idx_nxt       = r_idx;

    case (r_state)
      ST_IDLE: begin
        if (CMD_VALID) begin
          // Bit 0 goes straight to the pins; the rest wait in the shifters.
          w_tms_sh_nxt  = CMD_TMS >> 1;
          w_tdi_sh_nxt  = CMD_TDI >> 1;
          w_len_nxt     = w_len_clamp;
          w_idx_nxt     = '0;
          w_mask_nxt    = DATA_W'(1);
          w_rsp_tdo_nxt = '0;
          if (w_len_clamp == '0) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_tms_nxt   = CMD_TMS[0];
            w_tdi_nxt   = CMD_TDI[0];
            w_state_nxt = ST_LOW;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_LOW: begin
        if (w_rise_stb) begin
          w_tck_nxt   = 1'b1;
          w_state_nxt = ST_HIGH;
        end else begin
          w_state_nxt = ST_LOW;
        end
      end

      ST_HIGH: begin
        if (w_fall_stb) begin
          // TDO is sampled on the same edge that drops TCK, i.e. late in TCK-high.
          w_tck_nxt     = 1'b0;
          w_rsp_tdo_nxt = r_rsp_tdo | (TDO ? r_mask : '0);
          if (w_idx_inc < r_len) begin
            w_idx_nxt    = w_idx_inc;
            w_mask_nxt   = r_mask << 1;
            w_tms_nxt    = r_tms_sh[0];
            w_tdi_nxt    = r_tdi_sh[0];
            w_tms_sh_nxt = r_tms_sh >> 1;
            w_tdi_sh_nxt = r_tdi_sh >> 1;
            w_state_nxt  = ST_LOW;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end else begin
          w_state_nxt = ST_HIGH;
        end
      end

      ST_DONE: begin
        // First DONE cycle raises RSP_VALID; the second drops it and returns to
        // IDLE, so CMD_READY only comes back the cycle after the response pulse.
        if (!r_rsp_valid) begin
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = ST_DONE;
        end else begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset parks TCK low with TMS high.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_tck       <= 1'b0;
      r_tms       <= 1'b1;
      r_tdi       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_tdo   <= '0;
      r_tms_sh    <= '0;
      r_tdi_sh    <= '0;
      r_mask      <= '0;
      r_len       <= '0;
      r_idx       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_tck       <= w_tck_nxt;
      r_tms       <= w_tms_nxt;
      r_tdi       <= w_tdi_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_tdo   <= w_rsp_tdo_nxt;
      r_tms_sh    <= w_tms_sh_nxt;
      r_tdi_sh    <= w_tdi_sh_nxt;
      r_mask      <= w_mask_nxt;
      r_len       <= w_len_nxt;
      r_idx       <= w_idx_nxt;
    end
  end

endmodule

// File: tb/tb_jtag_master_shifter.sv
// Directed bench for jtag_master_shifter: instance A (DATA_W=32, DIV=2) and
// instance B (DATA_W=8, DIV=1), each driving a small target model that
// updates TDO on TCK falling edges and samples TDI/TMS on rising edges.
module tb_jtag_master_shifter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A signals
  logic        valid_a, ready_a, rspv_a, tck_a, tms_a, tdi_a, tdo_a;
  logic [5:0]  len_a;
  logic [31:0] tms_cmd_a, tdi_cmd_a, rsptdo_a;
  // Instance B signals
  logic        valid_b, ready_b, rspv_b, tck_b, tms_b, tdi_b, tdo_b;
  logic [3:0]  len_b;
  logic [7:0]  tms_cmd_b, tdi_cmd_b, rsptdo_b;

  jtag_master_shifter #(.DATA_W(32), .DIV(2)) u_dut_a (
    .CLK(clk), .RST(rst), .CMD_VALID(valid_a), .CMD_READY(ready_a),
    .CMD_LEN(len_a), .CMD_TMS(tms_cmd_a), .CMD_TDI(tdi_cmd_a),
    .RSP_VALID(rspv_a), .RSP_TDO(rsptdo_a),
    .TCK(tck_a), .TMS(tms_a), .TDI(tdi_a), .TDO(tdo_a)
  );

  jtag_master_shifter #(.DATA_W(8), .DIV(1)) u_dut_b (
    .CLK(clk), .RST(rst), .CMD_VALID(valid_b), .CMD_READY(ready_b),
    .CMD_LEN(len_b), .CMD_TMS(tms_cmd_b), .CMD_TDI(tdi_cmd_b),
    .RSP_VALID(rspv_b), .RSP_TDO(rsptdo_b),
    .TCK(tck_b), .TMS(tms_b), .TDI(tdi_b), .TDO(tdo_b)
  );

  // Target model A: TDO = bit (falls since base) of the preloaded pattern.
  logic [31:0] pat_a = 32'h0;
  logic [31:0] sh_a;
  int fall_a = 0, rise_a = 0, fbase_a = 0, tms0_a = 0, rsp_cnt_a = 0;
  assign sh_a  = pat_a >> (fall_a - fbase_a);
  assign tdo_a = sh_a[0];
  always @(negedge tck_a) fall_a = fall_a + 1;
  always @(posedge tck_a) begin
    rise_a = rise_a + 1;
    if (tms_a !== 1'b1) tms0_a = tms0_a + 1;
  end
  always @(posedge clk) if (rspv_a === 1'b1) rsp_cnt_a = rsp_cnt_a + 1;

  // Target model B: 8-bit shift register preloaded 8'h3C, received TDI/TMS logs.
  logic [7:0] pat_b = 8'h3C;
  logic [7:0] sh_b;
  logic [7:0] rx_b, tmslog_b;
  int fall_b = 0, rise_b = 0, fbase_b = 0;
  assign sh_b  = pat_b >> (fall_b - fbase_b);
  assign tdo_b = sh_b[0];
  always @(negedge tck_b) fall_b = fall_b + 1;
  always @(posedge tck_b) begin
    rise_b   = rise_b + 1;
    rx_b     = {tdi_b, rx_b[7:1]};
    tmslog_b = {tms_b, tmslog_b[7:1]};
  end

  // Pin monitors: TMS/TDI must not move while TCK is high; A's TCK-high runs are DIV cycles.
  logic prev_tms_a, prev_tdi_a, prev_tms_b, prev_tdi_b;
  int viol = 0, bad_hi_a = 0, hi_run_a = 0;
  always @(negedge clk) begin
    if (tck_a === 1'b1 && (tms_a !== prev_tms_a || tdi_a !== prev_tdi_a)) viol = viol + 1;
    if (tck_b === 1'b1 && (tms_b !== prev_tms_b || tdi_b !== prev_tdi_b)) viol = viol + 1;
    prev_tms_a = tms_a; prev_tdi_a = tdi_a;
    prev_tms_b = tms_b; prev_tdi_b = tdi_b;
    if (rst === 1'b1) begin
      hi_run_a = 0;
    end else if (tck_a === 1'b1) begin
      hi_run_a = hi_run_a + 1;
    end else begin
      if (hi_run_a != 0 && hi_run_a != 2) bad_hi_a = bad_hi_a + 1;
      hi_run_a = 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for RSP_VALID on A; n is CLK edges since the accept edge.
  task automatic wait_rsp_a(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (rspv_a !== 1'b1 && n < 500);
  endtask

  task automatic run_a(input string tag, input logic [5:0] len, input logic [31:0] tms,
                       input logic [31:0] tdi, input logic [31:0] pat, input int exp_cyc,
                       input int exp_pulses, input logic [31:0] exp_tdo, input logic exp_tms);
    int n;
    int r0;
    pat_a = pat; fbase_a = fall_a; r0 = rise_a;
    len_a = len; tms_cmd_a = tms; tdi_cmd_a = tdi; valid_a = 1'b1;
    @(posedge clk); #1;
    valid_a = 1'b0;
    chk({tag, "_busy"}, ready_a, 1'b0);
    chk({tag, "_clr"}, rsptdo_a, 32'h0);
    wait_rsp_a(n);
    chk({tag, "_lat"}, n, exp_cyc);
    chk({tag, "_rdy_in_rsp"}, ready_a, 1'b0);
    chk({tag, "_tdo"}, rsptdo_a, exp_tdo);
    chk({tag, "_pulses"}, rise_a - r0, exp_pulses);
    @(posedge clk); #1;
    chk({tag, "_rdy_after"}, ready_a, 1'b1);
    chk({tag, "_rspv_1cyc"}, rspv_a, 1'b0);
    chk({tag, "_tck_idle"}, tck_a, 1'b0);
    chk({tag, "_tms_hold"}, tms_a, exp_tms);
    chk({tag, "_tdo_hold"}, rsptdo_a, exp_tdo);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n, r0, t0, rc0, k;
    rst = 1'b1;
    valid_a = 1'b0; len_a = 6'd0; tms_cmd_a = 32'h0; tdi_cmd_a = 32'h0;
    valid_b = 1'b0; len_b = 4'd0; tms_cmd_b = 8'h0;  tdi_cmd_b = 8'h0;
    repeat (3) @(posedge clk);
    #1;
    // Reset values {TCK,TMS,TDI,CMD_READY,RSP_VALID}
    chk("rst_pins_a", {tck_a, tms_a, tdi_a, ready_a, rspv_a}, 5'b01010);
    chk("rst_tdo_a", rsptdo_a, 32'h0);
    chk("rst_pins_b", {tck_b, tms_b, tdi_b, ready_b, rspv_b}, 5'b01010);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("idle_pins_a", {tck_a, tms_a, tdi_a, ready_a, rspv_a}, 5'b01010);
    end

    // TAP reset walk: 5 pulses, TMS high on every rise, RSP at accept+21.
    t0 = tms0_a;
    run_a("walk", 6'd5, 32'h1F, 32'h0, 32'hFFFF_FFF5, 21, 5, 32'h15, 1'b1);
    chk("walk_tms_high", t0 - tms0_a, 0);

    // DIV=1, 8-bit exchange with the preloaded target on instance B.
    fbase_b = fall_b; r0 = rise_b;
    len_b = 4'd8; tms_cmd_b = 8'h80; tdi_cmd_b = 8'hA5; valid_b = 1'b1;
    @(posedge clk); #1;
    valid_b = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (rspv_b !== 1'b1 && n < 500);
    chk("xchg_lat", n, 17);
    chk("xchg_tdo", rsptdo_b, 8'h3C);
    chk("xchg_rx", rx_b, 8'hA5);
    chk("xchg_tms_log", tmslog_b, 8'h80);
    chk("xchg_pulses", rise_b - r0, 8);
    @(posedge clk); #1;
    chk("xchg_rdy", ready_b, 1'b1);
    chk("xchg_tms_hold", tms_b, 1'b1);

    // Zero-length command and over-length clamp.
    run_a("len0", 6'd0, 32'h0, 32'h0, 32'hFFFF_FFFF, 1, 0, 32'h0, 1'b1);
    run_a("len40", 6'd40, 32'h8000_0001, 32'h1234_5678, 32'hDEAD_BEEF, 129, 32, 32'hDEAD_BEEF, 1'b1);

    // Back-to-back with CMD_VALID held: target pattern spans both commands.
    pat_a = 32'h1D; fbase_a = fall_a;
    len_a = 6'd3; tms_cmd_a = 32'h0; tdi_cmd_a = 32'h5; valid_a = 1'b1;
    @(posedge clk); #1;
    chk("b2b_acc1", ready_a, 1'b0);
    tms_cmd_a = 32'h3; tdi_cmd_a = 32'h2;
    wait_rsp_a(n);
    chk("b2b_lat1", n, 13);
    chk("b2b_tdo1", rsptdo_a, 32'h5);
    chk("b2b_rdy_in_rsp", ready_a, 1'b0);
    @(posedge clk); #1;
    chk("b2b_rdy_gap", ready_a, 1'b1);
    @(posedge clk); #1;
    chk("b2b_acc2", ready_a, 1'b0);
    chk("b2b_clr2", rsptdo_a, 32'h0);
    valid_a = 1'b0;
    wait_rsp_a(n);
    chk("b2b_lat2", n, 13);
    chk("b2b_tdo2", rsptdo_a, 32'h3);
    @(posedge clk); #1;
    chk("b2b_tms_hold", tms_a, 1'b0);

    // Reset during pulse 3 of an 8-pulse command.
    pat_a = 32'h0; r0 = rise_a; rc0 = rsp_cnt_a;
    len_a = 6'd8; tms_cmd_a = 32'h0; tdi_cmd_a = 32'hFF; valid_a = 1'b1;
    @(posedge clk); #1;
    valid_a = 1'b0;
    k = 0;
    while ((rise_a - r0) < 3 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk("rst_reach_p3", rise_a - r0, 3);
    chk("rst_pre_tck", tck_a, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_pins", {tck_a, tms_a, tdi_a, ready_a, rspv_a}, 5'b01010);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("rst_no_rsp", rsp_cnt_a - rc0, 0);
    chk("rst_tdo_zero", rsptdo_a, 32'h0);
    run_a("post_rst", 6'd4, 32'h6, 32'h9, 32'hB, 17, 4, 32'hB, 1'b0);

    chk("pins_stable_tck_high", viol, 0);
    chk("tck_high_len", bad_hi_a, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
